// File: rtl/submarine_shooter.sv
// Attacking player for the submarine game: raster hunt plus
// stack-driven neighbour targeting after a non-sinking hit.
module submarine_shooter #(
    parameter int STACK_DEPTH  = 8,
    parameter int RESP_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       cord_valid,
    input  logic       busy,
    input  logic       hit,
    input  logic       sink,
    input  logic       done,
    output logic       running,
    output logic       finished,
    output logic       result_valid,
    output logic       result_hit,
    output logic [6:0] shots_cnt,
    output logic [6:0] hits_cnt,
    output logic [3:0] sinks_cnt
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [PW:0]   SP_FULL = (PW + 1)'(STACK_DEPTH);
    localparam logic [TW-1:0] TMO_MAX = TW'(RESP_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SELECT    = 3'd1;
    localparam logic [2:0] S_FIRE      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic [2:0]    state;
    logic [63:0]   shot_map;
    logic [5:0]    stack_q [STACK_DEPTH];
    logic [PW:0]   sp;
    logic [5:0]    scan_ptr;
    logic [TW-1:0] tmo;
    logic          s_hit;
    logic          s_sink;
    logic          s_done;

    logic [PW:0]   sp_m1;
    logic [5:0]    top_cell;
    logic [5:0]    free_idx;
    logic          free_any;
    logic [3:0]    nb_ok;
    logic [3:0][5:0] nb_cell;
    logic [5:0]    push_stack [STACK_DEPTH];
    logic [PW:0]   push_sp;

    assign sp_m1    = sp - 1'b1;
    assign top_cell = stack_q[sp_m1[PW-1:0]];

    // Every cell below the scan pointer is already shot, so the first
    // unshot cell at or above it is the next raster target.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (!shot_map[i] && (6'(i) >= scan_ptr)) begin
                free_any = 1'b1;
                free_idx = 6'(i);
            end
        end
    end

    always_comb begin
        nb_ok[0]   = (x != 3'd0);
        nb_cell[0] = {y, x - 3'd1};
        nb_ok[1]   = (x != 3'd7);
        nb_cell[1] = {y, x + 3'd1};
        nb_ok[2]   = (y != 3'd0);
        nb_cell[2] = {y - 3'd1, x};
        nb_ok[3]   = (y != 3'd7);
        nb_cell[3] = {y + 3'd1, x};
    end

    // Neighbours go on in fixed order; once full the rest are dropped.
    always_comb begin
        push_stack = stack_q;
        push_sp    = sp;
        for (int k = 0; k < 4; k++) begin
            if (nb_ok[k] && !shot_map[nb_cell[k]] && (push_sp < SP_FULL)) begin
                push_stack[push_sp[PW-1:0]] = nb_cell[k];
                push_sp = push_sp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            shot_map     <= '0;
            sp           <= '0;
            scan_ptr     <= '0;
            tmo          <= '0;
            s_hit        <= 1'b0;
            s_sink       <= 1'b0;
            s_done       <= 1'b0;
            x            <= '0;
            y            <= '0;
            cord_valid   <= 1'b0;
            running      <= 1'b0;
            finished     <= 1'b0;
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            shots_cnt    <= '0;
            hits_cnt     <= '0;
            sinks_cnt    <= '0;
        end else begin
            cord_valid   <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        shot_map   <= '0;
                        sp         <= '0;
                        scan_ptr   <= '0;
                        x          <= '0;
                        y          <= '0;
                        result_hit <= 1'b0;
                        shots_cnt  <= '0;
                        hits_cnt   <= '0;
                        sinks_cnt  <= '0;
                        running    <= 1'b1;
                        finished   <= 1'b0;
                        state      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (sp != '0) begin
                        sp <= sp_m1;
                        // A stale entry is dropped and SELECT runs again.
                        if (!shot_map[top_cell]) begin
                            x     <= top_cell[2:0];
                            y     <= top_cell[5:3];
                            state <= S_FIRE;
                        end
                    end else if (free_any) begin
                        scan_ptr <= free_idx;
                        x        <= free_idx[2:0];
                        y        <= free_idx[5:3];
                        state    <= S_FIRE;
                    end else begin
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= S_FINISH;
                    end
                end
                S_FIRE: begin
                    if (!busy) begin
                        cord_valid         <= 1'b1;
                        shot_map[{y, x}]   <= 1'b1;
                        shots_cnt          <= shots_cnt + 7'd1;
                        tmo                <= '0;
                        state              <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo == TMO_MAX) begin
                        s_hit        <= hit;
                        s_sink       <= sink;
                        s_done       <= done;
                        result_valid <= 1'b1;
                        result_hit   <= hit;
                        state        <= S_UPDATE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!busy) begin
                        s_hit        <= hit;
                        s_sink       <= sink;
                        s_done       <= done;
                        result_valid <= 1'b1;
                        result_hit   <= hit;
                        state        <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (s_hit) begin
                        hits_cnt <= hits_cnt + 7'd1;
                    end
                    if (s_sink) begin
                        if (sinks_cnt != 4'hF) begin
                            sinks_cnt <= sinks_cnt + 4'd1;
                        end
                        sp <= '0;
                    end else if (s_hit) begin
                        stack_q <= push_stack;
                        sp      <= push_sp;
                    end
                    if (s_done) begin
                        running  <= 1'b0;
                        finished <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_submarine_shooter.sv
// Randomised bench for submarine_shooter: a board-driven responder
// plus a queue-based hunt/target player model.
module tb_submarine_shooter;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [2:0] x, y;
    logic       cord_valid, busy, hit, sink, done;
    logic       running, finished, result_valid, result_hit;
    logic [6:0] shots_cnt, hits_cnt;
    logic [3:0] sinks_cnt;

    submarine_shooter #(.STACK_DEPTH(8), .RESP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .cord_valid(cord_valid), .busy(busy), .hit(hit), .sink(sink),
        .done(done), .running(running), .finished(finished),
        .result_valid(result_valid), .result_hit(result_hit),
        .shots_cnt(shots_cnt), .hits_cnt(hits_cnt), .sinks_cnt(sinks_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Board and responder
    int   sub_of [64];
    int   left [16];
    int   alive, nsubs, lat, bcnt, rc;
    logic rsp_busy = 1'b0, hold_busy = 1'b0;
    logic rsp_hit = 1'b0, rsp_sink = 1'b0, rsp_done = 1'b0;

    assign busy = rsp_busy | hold_busy;
    assign hit  = rsp_hit;
    assign sink = rsp_sink;
    assign done = rsp_done;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            bcnt = 0; rsp_busy = 1'b0;
            rsp_hit = 1'b0; rsp_sink = 1'b0; rsp_done = 1'b0;
        end else if (cord_valid) begin
            rc = int'({y, x});
            rsp_hit = (sub_of[rc] != 0);
            rsp_sink = 1'b0;
            if (rsp_hit) begin
                left[sub_of[rc]]--;
                if (left[sub_of[rc]] == 0) begin
                    rsp_sink = 1'b1;
                    alive--;
                end
            end
            rsp_done = (nsubs > 0) && (alive == 0);
            if (lat > 0) begin
                bcnt = lat; rsp_busy = 1'b1;
            end
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) rsp_busy = 1'b0;
        end
    end

    function automatic void clear_board();
        foreach (sub_of[i]) sub_of[i] = 0;
        foreach (left[i]) left[i] = 0;
        alive = 0; nsubs = 0;
    endfunction

    function automatic void add_sub(input int c0, input int dc,
                                    input int len, input int hp);
        nsubs++; alive++;
        for (int k = 0; k < len; k++) sub_of[c0 + k * dc] = nsubs;
        left[nsubs] = hp;
    endfunction

    function automatic void rand_board();
        int want, len, vert, x0, y0, ok;
        clear_board();
        want = $urandom_range(1, 4);
        for (int s = 0; s < want; s++) begin
            for (int t = 0; t < 40; t++) begin
                len  = $urandom_range(1, 3);
                vert = $urandom_range(0, 1);
                x0   = $urandom_range(0, 7);
                y0   = $urandom_range(0, 7);
                ok   = vert ? (y0 + len <= 8) : (x0 + len <= 8);
                for (int k = 0; k < len && ok; k++)
                    if (sub_of[(y0 + (vert ? k : 0)) * 8 + x0 + (vert ? 0 : k)] != 0)
                        ok = 0;
                if (ok) begin
                    add_sub(y0 * 8 + x0, vert ? 8 : 1, len, len);
                    break;
                end
            end
        end
    endfunction

    // Player model: LIFO of neighbour cells, raster fallback
    bit mshot [64];
    bit fired [64];
    int mstack [$];
    int shots_q [$];
    int mcur, mhits, msinks;
    bit mdone;

    function automatic void model_reset();
        foreach (mshot[i]) begin mshot[i] = 0; fired[i] = 0; end
        mstack.delete(); shots_q.delete();
        mcur = 0; mhits = 0; msinks = 0; mdone = 0;
    endfunction

    function automatic int model_next();
        int c;
        while (mstack.size() > 0) begin
            c = mstack.pop_back();
            if (!mshot[c]) return c;
        end
        for (int i = 0; i < 64; i++) if (!mshot[i]) return i;
        return -1;
    endfunction

    function automatic void try_push(input int nx, input int ny);
        if (nx < 0 || nx > 7 || ny < 0 || ny > 7) return;
        if (mshot[ny * 8 + nx] || mstack.size() >= 8) return;
        mstack.push_back(ny * 8 + nx);
    endfunction

    function automatic void model_update(input bit h, input bit s, input bit d);
        int cx, cy;
        cx = mcur % 8; cy = mcur / 8;
        if (h) mhits++;
        if (s) begin
            if (msinks < 15) msinks++;
            mstack.delete();
        end else if (h) begin
            try_push(cx - 1, cy);
            try_push(cx + 1, cy);
            try_push(cx, cy - 1);
            try_push(cx, cy + 1);
        end
        mdone = d;
    endfunction

    function automatic bit model_over();
        if (mdone) return 1;
        for (int i = 0; i < 64; i++) if (!mshot[i]) return 0;
        return 1;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_game(input int latency, input bit hold,
                            input bit pokes, input string tag);
        int cyc, stray, c, e;
        model_reset();
        lat = latency;
        hold_busy = hold;
        pulse_start();
        check({tag, ".run"}, running, 1);
        check({tag, ".shots0"}, shots_cnt, 0);
        check({tag, ".hits0"}, hits_cnt, 0);
        if (hold) begin
            stray = 0;
            repeat (6) begin
                @(negedge clk);
                if (cord_valid) stray++;
            end
            check({tag, ".stall"}, stray, 0);
            hold_busy = 1'b0;
        end
        cyc = 0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cord_valid) begin
                c = int'({y, x});
                e = model_next();
                if (e >= 0) begin
                    mshot[e] = 1;
                    mcur = e;
                end
                check({tag, ".xy"}, c, e);
                check({tag, ".refire"}, fired[c], 0);
                fired[c] = 1;
                shots_q.push_back(c);
            end
            if (result_valid) begin
                check({tag, ".rhit"}, result_hit, rsp_hit);
                model_update(rsp_hit, rsp_sink, rsp_done);
            end
            start = (pokes && busy && ($urandom_range(0, 15) == 0));
        end
        start = 1'b0;
        check({tag, ".budget"}, (cyc < 3000), 1);
        check({tag, ".over"}, model_over(), 1);
        check({tag, ".nshots"}, shots_cnt, shots_q.size());
        check({tag, ".shots"}, shots_cnt, 64'(shots_q.size() == 0 ? 0 : 0) + 64'(shots_q.size()));
        check({tag, ".hits"}, hits_cnt, mhits);
        check({tag, ".sinks"}, sinks_cnt, msinks);
        check({tag, ".stopped"}, running, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; lat = 2; bcnt = 0;
        clear_board();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.outs", {x, y, cord_valid, running, finished, result_valid,
                           result_hit, shots_cnt, hits_cnt, sinks_cnt}, 0);

        // Empty board, 2-cycle busy: pure raster hunt
        clear_board();
        run_game(2, 0, 0, "empty");
        check("empty.len", shots_q.size(), 64);
        check("empty.last", shots_q[63], 63);
        check("empty.fin", finished, 1);

        // Endless sub at (3,0): neighbours (4,0),(3,1) pushed, (3,1) first
        clear_board();
        add_sub(3, 1, 1, 100);
        run_game(2, 0, 0, "tgt");
        check("tgt.s4", shots_q[4], 11);
        check("tgt.s5", shots_q[5], 4);
        check("tgt.s6", shots_q[6], 5);

        // Sub (3,0)-(4,0) sinks, then resume raster; lone cell at (7,7)
        clear_board();
        add_sub(3, 1, 2, 2);
        add_sub(63, 1, 1, 1);
        run_game(1, 0, 0, "sink");
        check("sink.s6", shots_q[6], 5);
        check("sink.fin", finished, 1);

        // Restart after FINISH, busy held at start, timeout responder
        rand_board();
        run_game(0, 1, 0, "zlat");
        for (int g = 0; g < 5; g++) begin
            rand_board();
            run_game($urandom_range(0, 3), $urandom_range(0, 1), 1, "rnd");
        end

        // Reset in WAIT_DONE
        rand_board();
        lat = 3;
        pulse_start();
        cyc = 0;
        while (!busy && cyc < 200) begin @(negedge clk); cyc++; end
        check("mid.busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid.outs", {x, y, cord_valid, running, finished, result_valid,
                           result_hit, shots_cnt, hits_cnt, sinks_cnt}, 0);
        rand_board();
        run_game(3, 0, 0, "post");
        check("post.first", shots_q[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
